ifetch_unit: RTL
================

Name: ifetch_unit

Overview:
- Instruction fetch stage, directly upstream of ControlUnit.
- Owns the PC and issues in-order word reads to instruction memory over a valid/ready request port with an in-order response port.
- Buffers returned words and presents one instruction word per cycle on IWord, which ControlUnit decodes.
- Consumes ControlUnit's PCSelect together with the ALU branch/jump target to redirect fetch, and flushes the wrong-path words.

Parameters:
RESET_PC, 32'h0000_0000, PC fetched first after reset.
DEPTH, 2, maximum number of words in flight plus buffered; power of 2, range 2..8.
NOP_WORD, 32'h0000_0013, word driven on IWord when no valid instruction is present (addi x0,x0,0).

Ports:
clk  input  1  clock.
rst  input  1  reset; asynchronous, active-high.
imem_req_valid  output  1  fetch request valid.
imem_req_ready  input  1  memory accepts the request this cycle.
imem_addr  output  32  word-aligned fetch address.
imem_rsp_valid  input  1  response word valid; in order; at least 1 cycle after acceptance.
imem_rsp_data  input  32  response instruction word.
IWord  output  32  head instruction word, to ControlUnit.
PC  output  32  address of the head instruction.
iword_valid  output  1  IWord/PC hold a real instruction.
stall  input  1  downstream hold; head is not consumed.
PCSelect  input  1  from ControlUnit; head instruction redirects the PC.
alu_target  input  32  redirect target from the ALU.

Behaviour:
- Reset (async assert, synchronous release):
  - State IDLE; fetch_pc = RESET_PC; buffer empty; inflight = 0; discard = 0.
  - Outputs: iword_valid = 0, IWord = NOP_WORD, PC = RESET_PC, imem_req_valid = 0.
  - Reset mid-transaction abandons all outstanding responses.
  - The memory is reset by the same rst.
- States: IDLE, FETCH, DRAIN.
  - IDLE -> FETCH unconditionally on the first clock after reset deasserts.
  - FETCH -> DRAIN on a redirect while discard-after-update > 0.
  - DRAIN -> FETCH when discard reaches 0.
- Request issue:
  - imem_req_valid = 1 in FETCH when inflight + buffered < DEPTH; imem_addr = fetch_pc.
  - Accept when imem_req_valid && imem_req_ready: fetch_pc += 4 (wraps mod 2^32), inflight += 1.
  - While not accepted, imem_addr is held stable, except that a redirect may withdraw or retarget the request in the same cycle.
- Response handling:
  - imem_rsp_valid with discard > 0: drop the word, discard -= 1, inflight -= 1.
  - Otherwise push {data, pc} into the buffer and inflight -= 1.
  - A response with inflight = 0 is ignored.
  - Buffer overflow is impossible by credit.
- Head output:
  - Buffer non-empty: iword_valid = 1; IWord and PC show the head entry combinationally.
  - Buffer empty: IWord = NOP_WORD and PC = the last presented PC.
  - A response arriving into an empty buffer appears on IWord the following cycle (no bypass). Minimum fetch latency is request acceptance + memory latency + 1.
- Consume: iword_valid && !stall pops the head. A push and a pop in the same cycle are both performed.
- Redirect, when iword_valid && !stall && PCSelect:
  - Pop the head and flush the whole buffer.
  - fetch_pc <= {alu_target[31:2], 2'b00}.
  - discard <= inflight (after this cycle's accept and response updates); a request accepted in the redirect cycle is counted in discard.
  - A response arriving in the redirect cycle is dropped.
  - PCSelect is ignored when iword_valid = 0 or stall = 1.
- DRAIN:
  - No requests issued; iword_valid = 0.
  - A further redirect cannot occur in DRAIN, because no head is valid.
- Widths: PC arithmetic is 32-bit unsigned; inflight and discard are clog2(DEPTH)+1 bits.

Test Plan:
1. Reset, memory with ready = 1 and 1-cycle latency returning addr^32'hA5A5_0000, stall = 0 -> IWord sequence shows data for PCs 0x0, 0x4, 0x8, ...; the first iword_valid appears 3 cycles after reset release; one instruction per cycle sustained.
2. stall held high for 5 cycles with the buffer full (2 entries) -> imem_req_valid = 0; IWord/PC frozen at the head; no words lost after stall drops; order preserved.
3. Taken branch: PCSelect = 1 at PC 0x8, alu_target = 0x103, with 2 requests in flight -> fetch_pc = 0x100; both stale responses (0x0C, 0x10) dropped via DRAIN; next valid IWord has PC = 0x100.
4. imem_req_ready low for 4 cycles -> imem_addr held at the same value; after acceptance PC advances by 4 exactly once.
5. Async rst asserted mid-stream with a response pending -> outputs return to reset values immediately; after release the first IWord is the RESET_PC word, never a stale word.
6. Fetch_pc 0xFFFF_FFFC -> next request address 0x0000_0000 (wrap).

Source files
------------

// File: rtl/ifetch_unit.sv
// Instruction fetch stage: owns the PC, issues in-order word reads to
// instruction memory, buffers returned words and presents one instruction
// per cycle to ControlUnit. A taken redirect flushes the buffer and drops
// every response still in flight for the wrong path.
module ifetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2,
    parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic [31:0] IWord,
    output logic [31:0] PC,
    output logic        iword_valid,
    input  logic        stall,
    input  logic        PCSelect,
    input  logic [31:0] alu_target
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0] DEPTH_V = (CW+1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;

    logic [31:0]     fetch_pc;
    logic [31:0]     rsp_pc;
    logic [31:0]     last_pc;
    logic [CW-1:0]   inflight;
    logic [CW-1:0]   inflight_nxt;
    logic [CW-1:0]   discard;
    logic [CW-1:0]   discard_nxt;
    logic [CW-1:0]   count;

    logic [31:0]     buf_data [DEPTH];
    logic [31:0]     buf_pc   [DEPTH];
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;

    logic            buf_valid;
    logic            pop;
    logic            redirect;
    logic            accept;
    logic            rsp_take;
    logic            drop;
    logic            push;
    logic [CW:0]     occupancy;
    logic [31:0]     target_aligned;

    // Target bits [1:0] are ignored: fetch addresses are always word aligned.
    logic            unused_target_bits;
    assign unused_target_bits = ^alu_target[1:0];
    assign target_aligned     = {alu_target[31:2], 2'b00};

    // Head presentation, consume/redirect decode and request credit.
    always_comb begin
        buf_valid   = (count != '0);
        iword_valid = buf_valid;
        IWord       = buf_valid ? buf_data[rd_ptr] : NOP_WORD;
        PC          = buf_valid ? buf_pc[rd_ptr]   : last_pc;
        pop         = buf_valid && !stall;
        redirect    = pop && PCSelect;
        // The head popped this cycle frees its slot, so it is not counted;
        // this is what lets a 1-cycle memory sustain one word per cycle.
        occupancy      = {1'b0, inflight} + {1'b0, count} - (CW+1)'(pop);
        imem_req_valid = (state == FETCH) && (occupancy < DEPTH_V);
        imem_addr      = fetch_pc;
        accept         = imem_req_valid && imem_req_ready;
        rsp_take       = imem_rsp_valid && (inflight != '0);
        drop           = rsp_take && ((discard != '0) || redirect);
        push           = rsp_take && !drop;
    end

    // Credit and discard bookkeeping, plus next-state selection.
    always_comb begin
        inflight_nxt = inflight + CW'(accept) - CW'(rsp_take);
        discard_nxt  = discard;
        if (redirect) begin
            discard_nxt = inflight_nxt;
        end else if (rsp_take && (discard != '0)) begin
            discard_nxt = discard - CW'(1);
        end

        state_nxt = state;
        case (state)
            IDLE:    state_nxt = FETCH;
            FETCH:   if (redirect && (inflight_nxt != '0)) state_nxt = DRAIN;
            DRAIN:   if (discard_nxt == '0) state_nxt = FETCH;
            default: state_nxt = IDLE;
        endcase
    end

    // State register and fetch/response counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            inflight <= '0;
            discard  <= '0;
        end else begin
            state    <= state_nxt;
            inflight <= inflight_nxt;
            discard  <= discard_nxt;
        end
    end

    // Fetch PC, PC tag of the next kept response, and last presented PC.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            rsp_pc   <= RESET_PC;
            last_pc  <= RESET_PC;
        end else begin
            if (redirect) begin
                fetch_pc <= target_aligned;
                rsp_pc   <= target_aligned;
            end else begin
                if (accept) fetch_pc <= fetch_pc + 32'd4;
                if (push)   rsp_pc   <= rsp_pc + 32'd4;
            end
            if (buf_valid) last_pc <= PC;
        end
    end

    // Buffer pointers and fill level; a redirect empties the buffer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (redirect) begin
            rd_ptr <= wr_ptr;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Buffer storage; contents are only meaningful while counted.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_data[wr_ptr] <= imem_rsp_data;
            buf_pc[wr_ptr]   <= rsp_pc;
        end
    end

endmodule
